// File: rtl/segment_led_pkg.sv
// Shared constants for the seven-segment scan driver: active-high hex glyphs and polarity helper.
package segment_led_pkg;

  localparam logic [6:0] SEG_OFF = 7'h00;

  // Bit order {G,F,E,D,C,B,A}; element 0 is the glyph for nibble 0.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [6:0] apply_polarity(input logic [6:0] seg, input bit active_low);
    return active_low ? ~seg : seg;
  endfunction

endpackage

// File: rtl/segment_led_scan_driver_if.sv
// System-side bundle of the scan driver: value/strobe/blank in, pin drives and update status out.
interface segment_led_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] Value;
  logic                Update;
  logic                Blank;
  logic [6:0]          Segments;
  logic [DIGITS-1:0]   DigitEnable;
  logic                Pending;
  logic                UpdateDone;

  modport master (
    output Value, Update, Blank,
    input  Segments, DigitEnable, Pending, UpdateDone
  );

  modport slave (
    input  Value, Update, Blank,
    output Segments, DigitEnable, Pending, UpdateDone
  );
endinterface

// File: rtl/segment_led_hex_rom.sv
// Combinational nibble to active-high seven-segment glyph; zero latency, no flow control.
module segment_led_hex_rom
  import segment_led_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nibble_i];

endmodule

// File: rtl/segment_led_scan_driver.sv
// Multiplexed seven-segment scanner; outputs registered (1 cycle), updates applied at frame wrap, no backpressure.
// Optional leading-zero suppression: SEGMENT_LED_LEADING_ZERO_BLANK_EN.
module segment_led_scan_driver
  import segment_led_pkg::*;
#(
  parameter int DIGITS     = 4,
  parameter int DIVIDER    = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic                      Clk,
  input  logic                      nReset,
  segment_led_scan_driver_if.slave  bus
);

  localparam int                CNT_W    = $clog2(DIVIDER);
  localparam int                IDX_W    = $clog2(DIGITS);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DIVIDER - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(DIGITS - 1);
  localparam logic [6:0]        SEG_DARK = apply_polarity(SEG_OFF, ACTIVE_LOW);
  localparam logic [DIGITS-1:0] DIG_DARK = {DIGITS{ACTIVE_LOW}};

  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [DIGITS-1:0][3:0]  shadow_q, shadow_d;
  logic [DIGITS-1:0][3:0]  staging_q, staging_d;
  logic                    pending_q, pending_d;
  logic                    done_q, done_d;
  logic [6:0]              seg_q, seg_d;
  logic [DIGITS-1:0]       dig_q, dig_d;

  logic                    tick;
  logic                    frame_wrap;
  logic                    lz_blank;
  logic                    dark;
  logic [6:0]              rom_seg;
  logic [DIGITS-1:0]       dig_onehot;

  assign tick       = (cnt_q == CNT_LAST);
  assign frame_wrap = tick && (idx_q == IDX_LAST);

  always_comb begin
    cnt_d = tick ? '0 : cnt_q + 1'b1;
    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
  end

  // A strobe coinciding with the wrap bypasses staging so it is never left pending.
  always_comb begin
    staging_d = staging_q;
    shadow_d  = shadow_q;
    pending_d = pending_q;
    done_d    = 1'b0;
    if (bus.Update) begin
      staging_d = bus.Value;
    end
    if (frame_wrap && bus.Update) begin
      shadow_d  = bus.Value;
      pending_d = 1'b0;
      done_d    = 1'b1;
    end else if (frame_wrap && pending_q) begin
      shadow_d  = staging_q;
      pending_d = 1'b0;
      done_d    = 1'b1;
    end else if (bus.Update) begin
      pending_d = 1'b1;
    end
  end

  segment_led_hex_rom u_hex_rom (
    .nibble_i (shadow_q[idx_q]),
    .seg_o    (rom_seg)
  );

`ifdef SEGMENT_LED_LEADING_ZERO_BLANK_EN
  logic upper_zero;

  // Digit idx is a leading zero when it and every higher nibble are zero; digit 0 always shows.
  always_comb begin
    upper_zero = 1'b1;
    for (int j = 0; j < DIGITS; j++) begin
      if ((j >= int'(idx_q)) && (shadow_q[j] != 4'h0)) begin
        upper_zero = 1'b0;
      end
    end
    lz_blank = (idx_q != '0) && upper_zero;
  end
`else
  assign lz_blank = 1'b0;
`endif

  assign dark       = bus.Blank || lz_blank;
  assign dig_onehot = DIGITS'(1) << idx_q;

  always_comb begin
    seg_d = dark ? SEG_DARK : apply_polarity(rom_seg, ACTIVE_LOW);
    dig_d = ACTIVE_LOW ? ~dig_onehot : dig_onehot;
    if (dark || (cnt_q == '0)) begin
      dig_d = DIG_DARK;
    end
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      cnt_q     <= '0;
      idx_q     <= '0;
      shadow_q  <= '0;
      staging_q <= '0;
      pending_q <= 1'b0;
      done_q    <= 1'b0;
      seg_q     <= SEG_DARK;
      dig_q     <= DIG_DARK;
    end else begin
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shadow_q  <= shadow_d;
      staging_q <= staging_d;
      pending_q <= pending_d;
      done_q    <= done_d;
      seg_q     <= seg_d;
      dig_q     <= dig_d;
    end
  end

  assign bus.Segments    = seg_q;
  assign bus.DigitEnable = dig_q;
  assign bus.Pending     = pending_q;
  assign bus.UpdateDone  = done_q;

endmodule

// File: tb/tb_segment_led_scan_driver.sv
// Directed bench for segment_led_scan_driver with DIGITS=4, DIVIDER=4, ACTIVE_LOW=1.
module tb_segment_led_scan_driver;

  logic Clk = 1'b0;
  logic nReset;
  int   e;
  int   n_chk;
  int   n_fail;
  int   dones;

  always #5 Clk = ~Clk;

  segment_led_scan_driver_if #(.DIGITS(4)) bus ();

  segment_led_scan_driver #(
    .DIGITS     (4),
    .DIVIDER    (4),
    .ACTIVE_LOW (1'b1)
  ) dut (
    .Clk    (Clk),
    .nReset (nReset),
    .bus    (bus)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // e counts rising edges since reset release; sampling is 1 time unit after the edge.
  task automatic tick();
    @(posedge Clk);
    #1;
    e++;
  endtask

  task automatic run_to(input int n);
    while (e < n) tick();
  endtask

  // Outputs after edge k reflect cnt=(k-1)%4, idx=((k-1)/4)%4.
  task automatic check_frame(input logic [6:0] s0, input logic [6:0] s1, input logic [6:0] s2,
                             input logic [6:0] s3, input logic [3:0] lit, input string tag);
    logic [6:0] segs [4];
    logic [3:0] exp_en;
    int c;
    int i;
    segs = '{s0, s1, s2, s3};
    for (int k = 0; k < 16; k++) begin
      tick();
      c = (e - 1) % 4;
      i = ((e - 1) / 4) % 4;
      exp_en = (c == 0 || !lit[i]) ? 4'hF : ~(4'b0001 << i);
      check({tag, "_en"}, 16'(bus.DigitEnable), 16'(exp_en));
      if (c != 0) check({tag, "_seg"}, 16'(bus.Segments), 16'(lit[i] ? segs[i] : 7'h7F));
      check({tag, "_done"}, 16'(bus.UpdateDone), 16'h0);
      check({tag, "_pend"}, 16'(bus.Pending), 16'h0);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    e = 0;
    nReset = 1'b1;
    bus.Value = '0;
    bus.Update = 1'b0;
    bus.Blank = 1'b0;
    #2 nReset = 1'b0;

    for (int k = 0; k < 3; k++) begin
      tick();
      check("rst_seg", 16'(bus.Segments), 16'h7F);
      check("rst_en", 16'(bus.DigitEnable), 16'hF);
      check("rst_pend", 16'(bus.Pending), 16'h0);
      check("rst_done", 16'(bus.UpdateDone), 16'h0);
    end
    nReset = 1'b1;
    e = 0;

    // Single update, lands at wrap edge 16.
    run_to(2);
    bus.Value = 16'h1234;
    bus.Update = 1'b1;
    tick();
    bus.Update = 1'b0;
    bus.Value = 16'hFFFF;
    check("upd_pend", 16'(bus.Pending), 16'h1);
    while (e < 15) begin
      tick();
      check("upd_wait_pend", 16'(bus.Pending), 16'h1);
      check("upd_wait_done", 16'(bus.UpdateDone), 16'h0);
    end
    tick();
    check("upd_done", 16'(bus.UpdateDone), 16'h1);
    check("upd_pend_clr", 16'(bus.Pending), 16'h0);
    check_frame(7'h19, 7'h30, 7'h24, 7'h79, 4'hF, "f1234");

    // Double update within one frame.
    run_to(33);
    bus.Value = 16'hAAAA;
    bus.Update = 1'b1;
    tick();
    bus.Update = 1'b0;
    check("dbl_pend", 16'(bus.Pending), 16'h1);
    run_to(39);
    bus.Value = 16'h00F0;
    bus.Update = 1'b1;
    tick();
    bus.Update = 1'b0;
    bus.Value = 16'hFFFF;
    dones = 0;
    while (e < 48) begin
      tick();
      if (bus.UpdateDone === 1'b1) dones++;
    end
    check("dbl_count", 16'(dones), 16'h1);
    check("dbl_done_at_wrap", 16'(bus.UpdateDone), 16'h1);
    check("dbl_pend_clr", 16'(bus.Pending), 16'h0);
`ifdef SEGMENT_LED_LEADING_ZERO_BLANK_EN
    check_frame(7'h40, 7'h0E, 7'h40, 7'h40, 4'b0011, "f00F0");
`else
    check_frame(7'h40, 7'h0E, 7'h40, 7'h40, 4'hF, "f00F0");
`endif

    // Update coincident with the wrap edge 80.
    run_to(79);
    bus.Value = 16'h5678;
    bus.Update = 1'b1;
    tick();
    bus.Update = 1'b0;
    bus.Value = 16'h0000;
    check("col_done", 16'(bus.UpdateDone), 16'h1);
    check("col_pend", 16'(bus.Pending), 16'h0);
    check_frame(7'h00, 7'h78, 7'h02, 7'h12, 4'hF, "f5678");

    // Blank forces everything dark.
    bus.Blank = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("blank_en", 16'(bus.DigitEnable), 16'hF);
      check("blank_seg", 16'(bus.Segments), 16'h7F);
    end
    bus.Blank = 1'b0;
    run_to(102);
    check("unblank_en", 16'(bus.DigitEnable), 16'hD);
    check("unblank_seg", 16'(bus.Segments), 16'h78);

    // Reset mid-frame with a staged value.
    bus.Value = 16'h9999;
    bus.Update = 1'b1;
    tick();
    bus.Update = 1'b0;
    check("mid_pend", 16'(bus.Pending), 16'h1);
    #2 nReset = 1'b0;
    #1;
    check("mid_rst_seg", 16'(bus.Segments), 16'h7F);
    check("mid_rst_en", 16'(bus.DigitEnable), 16'hF);
    check("mid_rst_pend", 16'(bus.Pending), 16'h0);
    tick();
    check("mid_rst_hold_en", 16'(bus.DigitEnable), 16'hF);
    nReset = 1'b1;
    e = 0;
`ifdef SEGMENT_LED_LEADING_ZERO_BLANK_EN
    check_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0001, "fzero_a");
    check_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'b0001, "fzero_b");
`else
    check_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'hF, "fzero_a");
    check_frame(7'h40, 7'h40, 7'h40, 7'h40, 4'hF, "fzero_b");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
